// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: owns the PC, issues req/ack instruction fetches and hands one
// instruction at a time to decode over valid/ready; illegal addresses latch a sticky fault.
module instr_fetch_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_fetch_en,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic        o_if_valid,
  input  logic        i_if_ready,
  output logic [31:0] o_if_instr,
  output logic [31:0] o_if_pc,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_fault,
  output logic [31:0] o_fetch_count
);
  typedef enum logic [1:0] {IDLE, REQ, HOLD, FAULT} state_t;
  localparam logic [31:0] LIMIT = 32'(DEPTH_WORDS * 4);
  state_t      r_state;
  logic [31:0] r_pc, r_if_instr, r_if_pc, r_fetch_count;
  logic        w_pc_ok, w_rd_ok;
  state_t      w_seq_next, w_rd_next;
  assign w_pc_ok    = (r_pc[1:0] == 2'b00) && (r_pc < LIMIT);
  assign w_rd_ok    = (i_redirect_pc[1:0] == 2'b00) && (i_redirect_pc < LIMIT);
  assign w_seq_next = !i_fetch_en ? IDLE : w_pc_ok ? REQ : FAULT;
  // a misaligned redirect target faults even when fetching is disabled
  assign w_rd_next  = (i_redirect_pc[1:0] != 2'b00) ? FAULT : !i_fetch_en ? IDLE : w_rd_ok ? REQ : FAULT;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_pc          <= RESET_PC;
      r_if_instr    <= '0;
      r_if_pc       <= '0;
      r_fetch_count <= '0;
    end else if (r_state != FAULT) begin
      if (i_redirect) begin
        r_pc    <= i_redirect_pc;
        r_state <= w_rd_next;
      end else if (r_state == IDLE) begin
        r_state <= w_seq_next;
      end else if (r_state == REQ && i_mem_ack) begin
        r_if_instr <= i_mem_rdata;
        r_if_pc    <= r_pc;
        r_pc       <= r_pc + 32'd4;
        r_state    <= HOLD;
      end else if (r_state == HOLD && i_if_ready) begin
        r_fetch_count <= r_fetch_count + 32'd1;
        r_state       <= w_seq_next;
      end
    end
  end
  assign o_mem_req     = (r_state == REQ);
  assign o_mem_addr    = r_pc;
  assign o_if_valid    = (r_state == HOLD);
  assign o_if_instr    = r_if_instr;
  assign o_if_pc       = r_if_pc;
  assign o_fault       = (r_state == FAULT);
  assign o_fetch_count = r_fetch_count;
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb_instr_fetch_ctrl: directed scenarios plus a randomized run scored against an
// instruction-stream model (next address to deliver, accepted count).
module tb_instr_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_fetch_en = 1'b0, i_mem_ack = 1'b0, i_if_ready = 1'b0, i_redirect = 1'b0;
  logic [31:0] i_redirect_pc = '0, i_mem_rdata;
  logic        o_mem_req, o_if_valid, o_fault;
  logic [31:0] o_mem_addr, o_if_instr, o_if_pc, o_fetch_count;
  logic [31:0] mem [32];
  int          checks = 0, errors = 0;
  logic [31:0] model_pc, model_cnt;

  always #5 clk = ~clk;
  // memory returns garbage unless it acknowledges, so early capture is visible
  assign i_mem_rdata = i_mem_ack ? mem[o_mem_addr[6:2]] : 32'hDEAD_BEEF;

  instr_fetch_ctrl #(.RESET_PC(32'h0), .DEPTH_WORDS(32)) dut (
    .clk(clk), .rst_n(rst_n), .i_fetch_en(i_fetch_en),
    .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr), .i_mem_ack(i_mem_ack),
    .i_mem_rdata(i_mem_rdata), .o_if_valid(o_if_valid), .i_if_ready(i_if_ready),
    .o_if_instr(o_if_instr), .o_if_pc(o_if_pc), .i_redirect(i_redirect),
    .i_redirect_pc(i_redirect_pc), .o_fault(o_fault), .o_fetch_count(o_fetch_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mem_req", 32'(o_mem_req), 0);
    chk("rst_mem_addr", o_mem_addr, 32'h0);
    chk("rst_if_valid", 32'(o_if_valid), 0);
    chk("rst_if_instr", o_if_instr, 0);
    chk("rst_if_pc", o_if_pc, 0);
    chk("rst_fault", 32'(o_fault), 0);
    chk("rst_count", o_fetch_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    i_fetch_en = 1'b0; i_mem_ack = 1'b0; i_if_ready = 1'b0; i_redirect = 1'b0; i_redirect_pc = '0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'(i);
    // streaming with zero-wait memory: one instruction per 2 cycles
    do_reset;
    i_fetch_en = 1'b1; i_mem_ack = 1'b1; i_if_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick;
      chk("stream_req", 32'(o_mem_req), 1);
      chk("stream_addr", o_mem_addr, 32'(4 * i));
      tick;
      chk("stream_valid", 32'(o_if_valid), 1);
      chk("stream_pc", o_if_pc, 32'(4 * i));
      chk("stream_instr", o_if_instr, 32'(i));
    end
    tick;
    chk("stream_count", o_fetch_count, 8);
    // decode stall in HOLD at pc 8
    do_reset;
    i_fetch_en = 1'b1; i_mem_ack = 1'b1; i_if_ready = 1'b1;
    repeat (5) tick;
    i_if_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("stall_valid", 32'(o_if_valid), 1);
      chk("stall_pc", o_if_pc, 32'h8);
      chk("stall_instr", o_if_instr, 32'h2);
      chk("stall_req", 32'(o_mem_req), 0);
      chk("stall_count", o_fetch_count, 2);
    end
    i_if_ready = 1'b1;
    tick;
    chk("stall_release_count", o_fetch_count, 3);
    chk("stall_release_addr", o_mem_addr, 32'hC);
    // slow memory: ack arrives on the 4th request cycle
    do_reset;
    i_fetch_en = 1'b1; i_mem_ack = 1'b1; i_if_ready = 1'b1;
    tick; tick;
    i_mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("wait_req", 32'(o_mem_req), 1);
      chk("wait_addr", o_mem_addr, 32'h4);
      chk("wait_valid", 32'(o_if_valid), 0);
      if (i == 3) i_mem_ack = 1'b1;
    end
    tick;
    chk("wait_hold_valid", 32'(o_if_valid), 1);
    chk("wait_instr", o_if_instr, 32'h1);
    chk("wait_pc", o_if_pc, 32'h4);
    // redirect squashes the held instruction at pc 8
    do_reset;
    i_fetch_en = 1'b1; i_mem_ack = 1'b1; i_if_ready = 1'b1;
    repeat (6) tick;
    chk("redir_pre_pc", o_if_pc, 32'h8);
    i_redirect = 1'b1; i_redirect_pc = 32'h40;
    tick;
    i_redirect = 1'b0;
    chk("redir_squash_valid", 32'(o_if_valid), 0);
    chk("redir_count", o_fetch_count, 2);
    chk("redir_req", 32'(o_mem_req), 1);
    chk("redir_addr", o_mem_addr, 32'h40);
    tick;
    chk("redir_if_pc", o_if_pc, 32'h40);
    chk("redir_instr", o_if_instr, 32'h10);
    // misaligned redirect faults and the fault is sticky
    i_redirect = 1'b1; i_redirect_pc = 32'h42;
    tick;
    chk("mis_fault", 32'(o_fault), 1);
    chk("mis_req", 32'(o_mem_req), 0);
    chk("mis_valid", 32'(o_if_valid), 0);
    chk("mis_addr", o_mem_addr, 32'h42);
    i_redirect_pc = 32'h10;
    repeat (3) tick;
    chk("mis_sticky", 32'(o_fault), 1);
    chk("mis_sticky_req", 32'(o_mem_req), 0);
    chk("mis_sticky_addr", o_mem_addr, 32'h42);
    i_redirect = 1'b0;
    // running off the end of memory
    do_reset;
    chk("post_fault_clear", 32'(o_fault), 0);
    i_fetch_en = 1'b1; i_mem_ack = 1'b1; i_if_ready = 1'b1;
    i_redirect = 1'b1; i_redirect_pc = 32'h78;
    tick;
    i_redirect = 1'b0;
    chk("end_addr78", o_mem_addr, 32'h78);
    tick;
    tick;
    chk("end_addr7c", o_mem_addr, 32'h7C);
    chk("end_req7c", 32'(o_mem_req), 1);
    tick;
    chk("end_pc7c", o_if_pc, 32'h7C);
    chk("end_instr7c", o_if_instr, 32'h1F);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("end_fault", 32'(o_fault), 1);
      chk("end_noreq", 32'(o_mem_req), 0);
      chk("end_addr80", o_mem_addr, 32'h80);
      chk("end_count", o_fetch_count, 2);
    end
    // randomized traffic against the stream model
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    do_reset;
    model_pc = 32'h0; model_cnt = 32'h0;
    for (int c = 0; c < 600; c++) begin
      tick;
      chk("rnd_count", o_fetch_count, model_cnt);
      chk("rnd_fault", 32'(o_fault), 0);
      if (o_mem_req) chk("rnd_addr", o_mem_addr, model_pc);
      if (o_if_valid) begin
        chk("rnd_pc", o_if_pc, model_pc);
        chk("rnd_instr", o_if_instr, mem[model_pc[6:2]]);
      end
      i_fetch_en = ($urandom % 8) != 0;
      i_mem_ack = ($urandom % 3) != 0;
      i_if_ready = ($urandom % 2) != 0;
      i_redirect = (model_pc >= 32'h70) || (($urandom % 16) == 0);
      i_redirect_pc = 32'($urandom_range(0, 27)) * 4;
      if (i_redirect) model_pc = i_redirect_pc;
      else if (o_if_valid && i_if_ready) begin
        model_cnt++;
        model_pc += 4;
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
